// File: rtl/hazard_unit_pkg.sv
// Shared constants for the pipeline hazard unit:
// divider FSM state encoding and forward-select codes.
package hazard_unit_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_BUSY  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

endpackage

// File: rtl/hazard_unit_if.sv
// Bundle between the core (controller/datapath) and
// the hazard unit: stage control bits in, stall/flush/fwd out.
interface hazard_unit_if #(
  parameter int RW = 5
);

  logic [RW-1:0] rsD;
  logic [RW-1:0] rtD;
  logic [RW-1:0] rsE;
  logic [RW-1:0] rtE;
  logic [RW-1:0] writeregE;
  logic [RW-1:0] writeregM;
  logic [RW-1:0] writeregW;
  logic          regwriteE;
  logic          regwriteM;
  logic          regwriteW;
  logic          memtoregE;
  logic          memtoregM;
  logic          branchD;
  logic          divE;
  logic          div_doneE;

  logic          forwardaD;
  logic          forwardbD;
  logic [1:0]    forwardaE;
  logic [1:0]    forwardbE;
  logic          stallF;
  logic          stallD;
  logic          stallE;
  logic          flushE;
  logic          flushM;
  logic          div_startE;
  logic          div_busy;

  modport master (
    output rsD, rtD, rsE, rtE,
    output writeregE, writeregM, writeregW,
    output regwriteE, regwriteM, regwriteW,
    output memtoregE, memtoregM,
    output branchD, divE, div_doneE,
    input  forwardaD, forwardbD,
    input  forwardaE, forwardbE,
    input  stallF, stallD, stallE,
    input  flushE, flushM,
    input  div_startE, div_busy
  );

  modport slave (
    input  rsD, rtD, rsE, rtE,
    input  writeregE, writeregM, writeregW,
    input  regwriteE, regwriteM, regwriteW,
    input  memtoregE, memtoregM,
    input  branchD, divE, div_doneE,
    output forwardaD, forwardbD,
    output forwardaE, forwardbE,
    output stallF, stallD, stallE,
    output flushE, flushM,
    output div_startE, div_busy
  );

endinterface

// File: rtl/hazard_unit_div_handshake.sv
// Start/done handshake with the multi-cycle divider;
// freezes the front of the pipe while a DIV sits in E.
module div_handshake
  import hazard_unit_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_div,
  input  logic i_done,
  output logic o_stall,
  output logic o_start,
  output logic o_busy
);

  logic [1:0] r_state;
  logic [1:0] w_next;
  logic       w_idle;
  logic       w_start;
  logic       w_busy;
  logic       w_done;

  assign w_idle  = (r_state == S_IDLE);
  assign w_start = (r_state == S_START);
  assign w_busy  = (r_state == S_BUSY);
  assign w_done  = (r_state == S_DONE);

  // DONE returns to IDLE unconditionally so the DIV
  // still sitting in E cannot retrigger the divider.
  always_comb begin
    w_next = r_state;
    unique case (1'b1)
      w_idle:  if (i_div) w_next = S_START;
      w_start: w_next = S_BUSY;
      w_busy:  if (i_done) w_next = S_DONE;
      w_done:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  assign o_stall = !rst &&
    ((w_idle && i_div) || w_start || w_busy);
  assign o_start = !rst && w_start;
  assign o_busy  = !rst && (w_start || w_busy);

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard responder: forwarding selects,
// load-use / branch / divider stalls and flushes.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int RW = 5
) (
  input  logic         clk,
  input  logic         rst,
  hazard_unit_if.slave hz
);

  logic w_lwstall;
  logic w_brstall;
  logic w_divstall;
  logic w_div_start;
  logic w_div_busy;
  logic w_front;

  function automatic logic hit(
    input logic [RW-1:0] a,
    input logic [RW-1:0] b,
    input logic          en
  );
    return en && (a != '0) && (a == b);
  endfunction

  function automatic logic [1:0] fwd_sel(
    input logic [RW-1:0] src,
    input logic [RW-1:0] wm,
    input logic          rwm,
    input logic [RW-1:0] ww,
    input logic          rww
  );
    if (hit(src, wm, rwm))      return FWD_M;
    else if (hit(src, ww, rww)) return FWD_W;
    else                        return FWD_RF;
  endfunction

  assign hz.forwardaE = fwd_sel(hz.rsE,
    hz.writeregM, hz.regwriteM,
    hz.writeregW, hz.regwriteW);
  assign hz.forwardbE = fwd_sel(hz.rtE,
    hz.writeregM, hz.regwriteM,
    hz.writeregW, hz.regwriteW);

  assign hz.forwardaD =
    hit(hz.rsD, hz.writeregM, hz.regwriteM);
  assign hz.forwardbD =
    hit(hz.rtD, hz.writeregM, hz.regwriteM);

  assign w_lwstall = hz.memtoregE &&
    (hz.rtE != '0) &&
    ((hz.rsD == hz.rtE) || (hz.rtD == hz.rtE));

  // A branch resolves in D, so an ALU result still in E
  // or a load still in M cannot be bypassed yet.
  assign w_brstall = hz.branchD && (
    hit(hz.writeregE, hz.rsD, hz.regwriteE) ||
    hit(hz.writeregE, hz.rtD, hz.regwriteE) ||
    hit(hz.writeregM, hz.rsD, hz.memtoregM) ||
    hit(hz.writeregM, hz.rtD, hz.memtoregM));

  div_handshake u_div (
    .clk     (clk),
    .rst     (rst),
    .i_div   (hz.divE),
    .i_done  (hz.div_doneE),
    .o_stall (w_divstall),
    .o_start (w_div_start),
    .o_busy  (w_div_busy)
  );

  assign w_front = w_lwstall || w_brstall;

  assign hz.stallF     = w_front || w_divstall;
  assign hz.stallD     = w_front || w_divstall;
  assign hz.stallE     = w_divstall;
  assign hz.flushM     = w_divstall;
  assign hz.flushE     = w_front && !w_divstall;
  assign hz.div_startE = w_div_start;
  assign hz.div_busy   = w_div_busy;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit.
// One task per scenario, inline comparisons.
module tb_hazard_unit;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  hazard_unit_if #(.RW(5)) hif ();

  hazard_unit #(.RW(5)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hif)
  );

  // stallF, stallD, stallE, flushE, flushM
  wire [4:0] stl = {hif.stallF, hif.stallD,
    hif.stallE, hif.flushE, hif.flushM};

  task automatic clear();
    hif.rsD = '0; hif.rtD = '0;
    hif.rsE = '0; hif.rtE = '0;
    hif.writeregE = '0;
    hif.writeregM = '0;
    hif.writeregW = '0;
    hif.regwriteE = 1'b0;
    hif.regwriteM = 1'b0;
    hif.regwriteW = 1'b0;
    hif.memtoregE = 1'b0;
    hif.memtoregM = 1'b0;
    hif.branchD   = 1'b0;
    hif.divE      = 1'b0;
    hif.div_doneE = 1'b0;
  endtask

  task automatic test_reset();
    clear();
    rst = 1'b1;
    hif.divE = 1'b1;
    #1;
    checks++;
    if ({stl, hif.div_startE, hif.div_busy} !== 7'b0) begin
      failures++;
      $display("FAIL rst_ctl got=%b exp=%b",
        {stl, hif.div_startE, hif.div_busy}, 7'b0);
    end
    hif.divE = 1'b0;
    #1;
    checks++;
    if ({hif.forwardaE, hif.forwardbE, hif.forwardaD,
         hif.forwardbD} !== 6'b0) begin
      failures++;
      $display("FAIL rst_fwd got=%b exp=%b",
        {hif.forwardaE, hif.forwardbE, hif.forwardaD,
         hif.forwardbD}, 6'b0);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (stl !== 5'b0) begin
      failures++;
      $display("FAIL rst_rel got=%b exp=%b", stl, 5'b0);
    end
  endtask

  task automatic test_forward_e();
    clear();
    hif.rsE = 5'd3;
    hif.writeregM = 5'd3; hif.regwriteM = 1'b1;
    hif.writeregW = 5'd3; hif.regwriteW = 1'b1;
    #1;
    checks++;
    if (hif.forwardaE !== 2'b10) begin
      failures++;
      $display("FAIL fwdaE_m got=%b exp=10", hif.forwardaE);
    end
    hif.regwriteM = 1'b0;
    #1;
    checks++;
    if (hif.forwardaE !== 2'b01) begin
      failures++;
      $display("FAIL fwdaE_w got=%b exp=01", hif.forwardaE);
    end
    hif.rsE = 5'd0;
    hif.writeregW = 5'd0;
    #1;
    checks++;
    if (hif.forwardaE !== 2'b00) begin
      failures++;
      $display("FAIL fwdaE_r0 got=%b exp=00", hif.forwardaE);
    end
    hif.rtE = 5'd7;
    hif.writeregW = 5'd7; hif.regwriteW = 1'b1;
    hif.writeregM = 5'd6; hif.regwriteM = 1'b1;
    #1;
    checks++;
    if (hif.forwardbE !== 2'b01) begin
      failures++;
      $display("FAIL fwdbE_w got=%b exp=01", hif.forwardbE);
    end
    hif.writeregM = 5'd7;
    #1;
    checks++;
    if ({hif.forwardbE, hif.forwardaE} !== 4'b1000) begin
      failures++;
      $display("FAIL fwdbE_m got=%b exp=1000",
        {hif.forwardbE, hif.forwardaE});
    end
  endtask

  task automatic test_forward_d();
    clear();
    hif.rsD = 5'd4;
    hif.writeregM = 5'd4; hif.regwriteM = 1'b1;
    #1;
    checks++;
    if ({hif.forwardaD, hif.forwardbD} !== 2'b10) begin
      failures++;
      $display("FAIL fwdD_a got=%b exp=10",
        {hif.forwardaD, hif.forwardbD});
    end
    hif.rsD = 5'd0; hif.writeregM = 5'd0;
    #1;
    checks++;
    if ({hif.forwardaD, hif.forwardbD} !== 2'b00) begin
      failures++;
      $display("FAIL fwdD_r0 got=%b exp=00",
        {hif.forwardaD, hif.forwardbD});
    end
  endtask

  task automatic test_lwstall();
    clear();
    hif.memtoregE = 1'b1;
    hif.rtE = 5'd8; hif.rsD = 5'd8;
    #1;
    checks++;
    if (stl !== 5'b11010) begin
      failures++;
      $display("FAIL lw_rs got=%b exp=11010", stl);
    end
    hif.rtE = 5'd0;
    #1;
    checks++;
    if (stl !== 5'b00000) begin
      failures++;
      $display("FAIL lw_clr got=%b exp=00000", stl);
    end
    hif.rsD = 5'd0;
    #1;
    checks++;
    if (stl !== 5'b00000) begin
      failures++;
      $display("FAIL lw_r0 got=%b exp=00000", stl);
    end
    hif.rsD = 5'd1; hif.rtD = 5'd9; hif.rtE = 5'd9;
    #1;
    checks++;
    if (stl !== 5'b11010) begin
      failures++;
      $display("FAIL lw_rt got=%b exp=11010", stl);
    end
  endtask

  task automatic test_branch();
    clear();
    hif.branchD = 1'b1; hif.rtD = 5'd5;
    hif.regwriteE = 1'b1; hif.writeregE = 5'd5;
    #1;
    checks++;
    if (stl !== 5'b11010) begin
      failures++;
      $display("FAIL br_e got=%b exp=11010", stl);
    end
    hif.regwriteE = 1'b0; hif.writeregE = 5'd0;
    hif.writeregM = 5'd5; hif.regwriteM = 1'b1;
    hif.memtoregM = 1'b0;
    #1;
    checks++;
    if ({stl, hif.forwardbD} !== 6'b000001) begin
      failures++;
      $display("FAIL br_m_alu got=%b exp=000001",
        {stl, hif.forwardbD});
    end
    hif.memtoregM = 1'b1;
    #1;
    checks++;
    if (stl !== 5'b11010) begin
      failures++;
      $display("FAIL br_m_ld got=%b exp=11010", stl);
    end
    clear();
    hif.branchD = 1'b1;
    hif.regwriteE = 1'b1;
    #1;
    checks++;
    if (stl !== 5'b00000) begin
      failures++;
      $display("FAIL br_r0 got=%b exp=00000", stl);
    end
  endtask

  task automatic test_div();
    logic [10:0] sm = 11'h002;
    logic [10:0] bm = 11'h0FE;
    logic [10:0] tm = 11'h0FF;
    int starts = 0;
    clear();
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      hif.divE = (c <= 8);
      hif.div_doneE = (c == 7);
      #1;
      if (hif.div_startE) starts++;
      checks++;
      if ({hif.div_startE, hif.div_busy, hif.stallE,
           hif.flushM, hif.flushE} !==
          {sm[c], bm[c], tm[c], tm[c], 1'b0}) begin
        failures++;
        $display("FAIL div_c%0d got=%b exp=%b", c,
          {hif.div_startE, hif.div_busy, hif.stallE,
           hif.flushM, hif.flushE},
          {sm[c], bm[c], tm[c], tm[c], 1'b0});
      end
    end
    checks++;
    if (starts !== 1) begin
      failures++;
      $display("FAIL div_starts got=%0d exp=1", starts);
    end
  endtask

  task automatic test_back_to_back();
    logic [12:0] sm = 13'h0082;
    logic [12:0] bm = 13'h079E;
    logic [12:0] tm = 13'h07DF;
    int starts = 0;
    clear();
    hif.rtE = 5'd8; hif.rsD = 5'd8;
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      hif.divE = (c <= 11);
      hif.div_doneE = (c == 4) || (c == 10);
      hif.memtoregE = (c >= 8) && (c <= 10);
      #1;
      if (hif.div_startE) starts++;
      checks++;
      if ({hif.div_startE, hif.div_busy, hif.stallE,
           hif.flushE, hif.stallF} !==
          {sm[c], bm[c], tm[c], 1'b0, tm[c]}) begin
        failures++;
        $display("FAIL b2b_c%0d got=%b exp=%b", c,
          {hif.div_startE, hif.div_busy, hif.stallE,
           hif.flushE, hif.stallF},
          {sm[c], bm[c], tm[c], 1'b0, tm[c]});
      end
    end
    checks++;
    if (starts !== 2) begin
      failures++;
      $display("FAIL b2b_starts got=%0d exp=2", starts);
    end
  endtask

  task automatic test_reset_mid_div();
    clear();
    @(negedge clk);
    hif.divE = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (hif.div_startE !== 1'b1) begin
      failures++;
      $display("FAIL rmd_start got=%b exp=1", hif.div_startE);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({hif.div_busy, hif.stallE} !== 2'b11) begin
      failures++;
      $display("FAIL rmd_busy got=%b exp=11",
        {hif.div_busy, hif.stallE});
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({hif.div_startE, hif.div_busy, hif.stallE,
         hif.flushM} !== 4'b0) begin
      failures++;
      $display("FAIL rmd_rst got=%b exp=0000",
        {hif.div_startE, hif.div_busy, hif.stallE,
         hif.flushM});
    end
    @(negedge clk);
    #1;
    checks++;
    if ({hif.div_startE, hif.div_busy, hif.stallF} !== 3'b0) begin
      failures++;
      $display("FAIL rmd_hold got=%b exp=000",
        {hif.div_startE, hif.div_busy, hif.stallF});
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({hif.div_startE, hif.stallE} !== 2'b01) begin
      failures++;
      $display("FAIL rmd_rel got=%b exp=01",
        {hif.div_startE, hif.stallE});
    end
    @(negedge clk);
    #1;
    checks++;
    if (hif.div_startE !== 1'b1) begin
      failures++;
      $display("FAIL rmd_restart got=%b exp=1",
        hif.div_startE);
    end
    hif.divE = 1'b0;
    @(negedge clk);
    hif.div_doneE = 1'b1;
    @(negedge clk);
    hif.div_doneE = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if ({hif.div_startE, hif.div_busy, hif.stallE} !== 3'b0) begin
      failures++;
      $display("FAIL rmd_idle got=%b exp=000",
        {hif.div_startE, hif.div_busy, hif.stallE});
    end
  endtask

  initial begin
    test_reset();
    test_forward_e();
    test_forward_d();
    test_lwstall();
    test_branch();
    test_div();
    test_back_to_back();
    test_reset_mid_div();
    $display("TB_RESULT checks=%0d failures=%0d",
      checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline hazard responder for the 5-stage MIPS core.
- Consumes the stage control bits that the controller and datapath produce.
- Returns the stall, flush and forwarding selects that the controller's pipeline registers and the datapath muxes consume.
- Holds a small FSM that runs the start/done handshake with the external multi-cycle divider and freezes F/D/E while a DIV/DIVU occupies execute.

Parameters:
- RW, 5, register-address width.

Ports:
- clk  in  1  clock; all sequential logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- rsD, rtD  in  RW  decode source registers
- rsE, rtE  in  RW  execute source registers
- writeregE, writeregM, writeregW  in  RW  destination register per stage
- regwriteE, regwriteM, regwriteW  in  1  register write enable per stage
- memtoregE, memtoregM  in  1  load in stage
- branchD  in  1  branch in decode
- divE  in  1  DIV/DIVU in execute
- div_doneE  in  1  divider result valid, single-cycle pulse
- forwardaD, forwardbD  out  1  decode comparator bypass from M
- forwardaE, forwardbE  out  2  ALU operand select: 00 register file, 01 W, 10 M
- stallF, stallD, stallE  out  1  hold the stage register
- flushE  out  1  bubble into E
- flushM  out  1  bubble into M
- div_startE  out  1  divider start pulse
- div_busy  out  1  divider in flight

Behaviour:
- Reset:
  - state=IDLE.
  - div_startE=0, div_busy=0.
  - The divider stall term is 0, so all outputs are functions of the combinational terms only.
  - Reset mid-division returns to IDLE at once and drops div_startE and stall.
- Forwarding (combinational, register 0 never matches):
  - forwardaE=10 if rsE!=0 && rsE==writeregM && regwriteM.
  - Otherwise forwardaE=01 if rsE!=0 && rsE==writeregW && regwriteW.
  - Otherwise forwardaE=00.
  - M beats W when both match. forwardbE uses rtE with the same rules.
  - forwardaD = rsD!=0 && rsD==writeregM && regwriteM. forwardbD uses rtD the same way.
- lwstall = memtoregE && rtE!=0 && (rsD==rtE || rtD==rtE).
- branchstall = branchD && ((regwriteE && writeregE!=0 && writeregE∈{rsD,rtD}) || (memtoregM && writeregM!=0 && writeregM∈{rsD,rtD})).
- Divider FSM (IDLE, START, BUSY, DONE):
  - IDLE: if divE, go to START.
  - START: div_startE=1 for exactly 1 cycle, then go to BUSY.
  - BUSY: div_doneE is sampled only here. div_doneE=1 moves to DONE.
  - DONE: lasts 1 cycle, then IDLE. It blocks a restart by the same instruction, which is still in E.
  - div_doneE outside BUSY is ignored.
  - divstall = (IDLE && divE) || START || BUSY. This stall includes the done cycle.
  - div_busy = START || BUSY.
- Outputs:
  - stallF = stallD = lwstall || branchstall || divstall.
  - stallE = divstall.
  - flushM = divstall. This prevents a stalled E instruction being duplicated into the non-enabled M register.
  - flushE = (lwstall || branchstall) && !divstall. flushE is never asserted together with stallE.
- Back-to-back DIVs: the second reaches E the cycle after DONE and sees IDLE, so it starts normally.
- Minimum divider occupancy is 4 cycles: IDLE, START, BUSY with done, DONE.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE=2'd0, START=2'd1, BUSY=2'd2, DONE=2'd3.
  - Forward-select constants FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10.
- One sub-module, div_handshake, holds the FSM and produces divstall, div_startE and div_busy.
- Forwarding and stall equations stay in hazard_unit.

Test Plan:
- rsE=3, writeregM=3, regwriteM=1, writeregW=3, regwriteW=1 -> forwardaE=10. Then clear regwriteM -> forwardaE=01. Then set rsE=0 -> forwardaE=00.
- memtoregE=1, rtE=8, rsD=8 -> stallF=stallD=1, flushE=1, stallE=0, flushM=0. Then set rtE=0 -> all 0.
- branchD=1, rtD=5, regwriteE=1, writeregE=5 -> stall and flushE asserted. Then move the write to M with memtoregM=0 -> no stall, forwardbD=1.
- divE=1 held, div_doneE pulsed 6 cycles after START:
  - required: div_startE high exactly 1 cycle, at cycle 1.
  - stallE=flushM=1 from cycle 0 through the done cycle, then 0 in DONE.
  - no second start pulse.
- Two consecutive DIVs -> two start pulses separated by the full handshake; flushE stays 0 throughout, even when lwstall is true during BUSY.
- Assert rst while in BUSY -> state IDLE immediately, div_startE=div_busy=stallE=0. After rst drops with divE=1, a fresh start pulse follows 1 cycle later.
